// File: rtl/mask_scanner_pkg.sv
// Shared definitions for mask_scanner and its encoder: scan state encoding
// and default geometry, reused by other mask-handling blocks.
package mask_scanner_pkg;

  localparam int MS_WIDTH = 32;
  localparam int MS_IDX_W = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/mask_scanner_ffs_encoder.sv
// ffs_encoder: combinational find-first-set, lowest set bit wins.
// Returns index 0 and o_any=0 for an all-zero vector.
module ffs_encoder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Walk from the top down so the lowest set bit is the final assignment.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mask_scanner.sv
// mask_scanner: accepts a mask, streams out the index of each set bit one per
// handshake, flags the last one and pulses done afterwards.
// Build option MASK_SCANNER_MSB_FIRST_EN: emit indices highest-first.
module mask_scanner
  import mask_scanner_pkg::*;
#(
  parameter int WIDTH = MS_WIDTH,
  parameter int IDX_W = MS_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic             r_done, w_done_nxt;

  logic [WIDTH-1:0] w_enc_in;
  logic [IDX_W-1:0] w_enc_idx;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_rem_clr;
  logic             w_single;

`ifdef MASK_SCANNER_MSB_FIRST_EN
  // Reverse the bits so the lowest-first encoder finds the highest set bit;
  // WIDTH is a power of two, so WIDTH-1-idx is just ~idx.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) w_enc_in[i] = r_rem[WIDTH-1-i];
  end
  assign w_idx     = ~w_enc_idx;
  assign w_rem_clr = r_rem & ~(WIDTH'(1) << w_idx);
`else
  assign w_enc_in  = r_rem;
  assign w_idx     = w_enc_idx;
  assign w_rem_clr = r_rem & (r_rem - WIDTH'(1));
`endif

  ffs_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_ffs (
    .i_vec (w_enc_in),
    .o_idx (w_enc_idx),
    .o_any (w_any)
  );

  // Exactly one bit left: the current index is the final beat.
  assign w_single = w_any && ((r_rem & (r_rem - WIDTH'(1))) == '0);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_SCAN);
  assign busy      = (r_state == S_SCAN);
  assign out_index = w_any ? w_idx : '0;
  assign out_last  = w_single;
  assign done      = r_done;

  // Next-state: load on accept, peel one bit per output handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (mask != '0) begin
            w_rem_nxt   = mask;
            w_state_nxt = S_SCAN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (out_ready) begin
          w_rem_nxt = w_rem_clr;
          if (w_single) begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = '0;
      end
    endcase
  end

  // State, remaining-mask and done registers; reset drops any scan silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule
